inst_fetch: RTL
===============

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 64'h0000000080000000, first fetch address after reset.
REQ-002 Parameter NOP_INST, default 32'h00000013, instruction driven when no valid instruction is held.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  decode back-pressure; head instruction held while high.
REQ-006 branch_taken  input  1  redirect request, one-cycle pulse.
REQ-007 branch_target  input  64  redirect address, sampled when branch_taken=1.
REQ-008 imem_req  output  1  instruction-memory request valid.
REQ-009 imem_addr  output  64  request address.
REQ-010 imem_ready  input  1  memory completes the request this cycle; imem_rdata valid.
REQ-011 imem_rdata  input  32  fetched instruction word.
REQ-012 inst  output  32  instruction to decode.
REQ-013 PC_o  output  64  address of inst.
REQ-014 inst_valid  output  1  inst/PC_o hold a real fetched instruction.
REQ-015 misalign  output  1  misaligned redirect flagged (see Configuration).

Function
REQ-016 Fetch PC register (fpc) SHALL supply imem_addr; fpc advances by 4 on each accepted request.
REQ-017 A transaction SHALL complete in a cycle where imem_req=1 and imem_ready=1; imem_req and imem_addr SHALL stay stable until completion.
REQ-018 At most one transaction SHALL be outstanding; the next request SHALL be raised no earlier than the cycle after completion.
REQ-019 A 2-entry FIFO SHALL hold {pc, word}; a request SHALL be raised only if entries plus outstanding < 2.
REQ-020 imem_req, imem_addr, inst, PC_o, inst_valid SHALL be registered or driven from FIFO registers; no combinational path from imem_rdata or stall to any output.
REQ-021 Completed data SHALL appear on inst the cycle after the imem_ready edge when FIFO was empty (1-cycle latency).
REQ-022 When empty: inst=NOP_INST, PC_o=0, inst_valid=0.
REQ-023 Pop SHALL occur on an edge with inst_valid=1 and stall=0; push and pop in the same edge SHALL leave count unchanged.
REQ-024 On branch_taken: FIFO flushed, fpc=branch_target, inst_valid=0 next cycle; branch_taken SHALL take priority over stall, push and pop.
REQ-025 If a transaction is outstanding at redirect, it SHALL run to completion and its data SHALL be discarded (drop flag); request to target follows next cycle.
REQ-026 branch_taken coincident with imem_ready SHALL discard that response.
REQ-027 FIFO SHALL never overflow; a completion with FIFO full SHALL be impossible by REQ-019.
REQ-028 fpc SHALL wrap modulo 2^64.

Reset
REQ-029 With reset=1 at an edge: fpc=RESET_PC, FIFO empty, drop flag clear, imem_req=0, imem_addr=RESET_PC, inst=NOP_INST, PC_o=0, inst_valid=0, misalign=0.
REQ-030 First request SHALL be raised the first cycle after reset deasserts.
REQ-031 Reset mid-transaction SHALL abandon it; a late imem_ready after reset SHALL be ignored while imem_req=0.

Configuration
REQ-032 Macro FETCH_ALIGN_CHECK_EN: when defined, branch_target[1:0]!=0 SHALL set misalign=1, flush and halt fetching until next aligned redirect or reset; when undefined, branch_target[1:0] SHALL be forced to 0 and misalign tied 0.

Verification
REQ-033 Reset, imem_ready=1 always, stall=0 -> imem_addr 0x80000000, 0x80000004, ... ; inst sequence equals memory words, PC_o matching, one per cycle after 2-cycle start.
REQ-034 stall=1 for 5 cycles with FIFO filling -> inst/PC_o held constant, imem_req=0 once 2 entries stored, no word lost or duplicated.
REQ-035 branch_taken, target 0x80000100, while request outstanding with imem_ready delayed 3 cycles -> returned word discarded, next imem_addr=0x80000100, inst_valid=0 until its data returns.
REQ-036 branch_taken together with imem_ready and stall=1 -> response dropped, FIFO empty, redirect taken.
REQ-037 With FETCH_ALIGN_CHECK_EN, target 0x80000102 -> misalign=1, imem_req=0 until redirect to 0x80000200; without macro -> fetch from 0x80000100.
REQ-038 reset asserted while imem_req=1 -> next cycle all outputs at REQ-029 values, late imem_ready ignored.

Source files
------------

// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------------------------
// inst_fetch: single-outstanding instruction fetch unit with a 2-entry {pc, word} buffer.
//
// A fetch PC (fpc) feeds a registered request/address pair towards instruction memory. Returned
// words are queued in a 2-entry FIFO whose head drives the decode-side outputs. A branch redirect
// flushes the FIFO, retargets fpc and marks any in-flight transaction so that its data is dropped.
//
// Parameters
//   RESET_PC      first fetch address after reset
//   NOP_INST      instruction presented while no valid instruction is held
//
// Ports
//   CLK            in   1   clock, all state on the rising edge
//   reset          in   1   synchronous, active-high reset
//   stall          in   1   decode back-pressure, head instruction held while high
//   branch_taken   in   1   redirect pulse
//   branch_target  in  64   redirect address
//   imem_req       out  1   instruction-memory request valid
//   imem_addr      out 64   request address
//   imem_ready     in   1   memory completes the request this cycle
//   imem_rdata     in  32   fetched word, valid with imem_ready
//   inst           out 32   instruction to decode
//   PC_o           out 64   address of inst
//   inst_valid     out  1   inst/PC_o hold a real fetched instruction
//   misalign       out  1   a misaligned redirect halted fetching
//
// Build option
//   FETCH_ALIGN_CHECK_EN  when defined, a redirect with branch_target[1:0] != 0 raises misalign,
//                         flushes and halts fetching until an aligned redirect or reset. When not
//                         defined, the two low target bits are cleared and misalign is tied low.
// ---------------------------------------------------------------------------------------------
module inst_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [63:0] PC_o,
    output logic        inst_valid,
    output logic        misalign
);

    typedef enum logic [0:0] {
        StIdle,
        StBusy
    } fetch_state_e;

    fetch_state_e state_q, state_d;

    logic [63:0] fpc_q, fpc_d;
    logic [63:0] addr_q, addr_d;
    logic        drop_q, drop_d;

    logic [63:0] fifo_pc_q   [2];
    logic [63:0] fifo_pc_d   [2];
    logic [31:0] fifo_word_q [2];
    logic [31:0] fifo_word_d [2];
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [1:0]  count_q, count_d;

    logic        complete;
    logic        push;
    logic        pop;
    logic [63:0] redirect_pc;
    logic        halted;

    // ------------------------------------------------------------------------------------------
    // Redirect target handling
    // ------------------------------------------------------------------------------------------
`ifdef FETCH_ALIGN_CHECK_EN
    logic halt_q, halt_d;

    assign redirect_pc = branch_target;

    // Every redirect re-evaluates the halt: an aligned one resumes, a misaligned one halts.
    always_comb begin
        halt_d = halt_q;
        if (branch_taken) begin
            halt_d = |branch_target[1:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            halt_q <= 1'b0;
        end else begin
            halt_q <= halt_d;
        end
    end

    assign halted   = halt_q;
    assign misalign = halt_q;
`else
    // Masking keeps every target bit in use while forcing word alignment.
    assign redirect_pc = branch_target & ~64'h3;
    assign halted      = 1'b0;
    assign misalign    = 1'b0;
`endif

    // ------------------------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        fpc_d       = fpc_q;
        addr_d      = addr_q;
        drop_d      = drop_q;
        fifo_pc_d   = fifo_pc_q;
        fifo_word_d = fifo_word_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;

        complete = (state_q == StBusy) && imem_ready;
        // A response is kept only if it was not orphaned by an earlier or simultaneous redirect.
        push     = complete && !drop_q && !branch_taken;
        pop      = (count_q != 2'd0) && !stall && !branch_taken;

        // FIFO
        if (branch_taken) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                fifo_pc_d[wr_ptr_q]   = addr_q;
                fifo_word_d[wr_ptr_q] = imem_rdata;
                wr_ptr_d              = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end

        // Request FSM
        if (complete) begin
            state_d = StIdle;
            drop_d  = 1'b0;
        end

        if (branch_taken) begin
            fpc_d  = redirect_pc;
            // An in-flight request keeps its address until memory answers; its data is dropped.
            drop_d = (state_q == StBusy) && !imem_ready;
        end else if ((state_d == StIdle) && !halted && (count_d != 2'd2)) begin
            // With nothing outstanding, a free slot guarantees the response can be stored.
            state_d = StBusy;
            addr_d  = fpc_q;
            fpc_d   = fpc_q + 64'd4;
        end
    end

    // ------------------------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= StIdle;
            fpc_q       <= RESET_PC;
            addr_q      <= RESET_PC;
            drop_q      <= 1'b0;
            fifo_pc_q   <= '{default: '0};
            fifo_word_q <= '{default: '0};
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            fpc_q       <= fpc_d;
            addr_q      <= addr_d;
            drop_q      <= drop_d;
            fifo_pc_q   <= fifo_pc_d;
            fifo_word_q <= fifo_word_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
        end
    end

    // ------------------------------------------------------------------------------------------
    // Outputs: driven only from registers
    // ------------------------------------------------------------------------------------------
    assign imem_req   = (state_q == StBusy);
    assign imem_addr  = addr_q;
    assign inst_valid = (count_q != 2'd0);
    assign inst       = inst_valid ? fifo_word_q[rd_ptr_q] : NOP_INST;
    assign PC_o       = inst_valid ? fifo_pc_q[rd_ptr_q] : 64'd0;

endmodule
